// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared FSM encoding and sizing constants for the multiplier scheduler
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 6;
  localparam int ID_W          = 1;

endpackage

// File: rtl/seq_mult_core.sv
// rtl/seq_mult_core.sv - shift-add sequential multiplier, one partial product per cycle
module seq_mult_core
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               running;

  // done marks the cycle whose edge performs the last step, so the caller
  // can leave RUN on the same edge that the final sum lands in acc
  assign done    = running && (count == CW'(WIDTH - 1));
  assign product = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      acc     <= '0;
      mplier  <= b;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin sharing of one sequential multiplier between two requesters
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic              accept;
  logic              core_done;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;

  // the pointer only breaks ties; a lone requester wins regardless of it
  assign grant = (req0_valid && req1_valid) ? ptr : ID_W'(req1_valid);
  assign op_a  = (grant == 1'b1) ? req1_a : req0_a;
  assign op_b  = (grant == 1'b1) ? req1_b : req0_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && (grant == 1'b0);
          req1_ready = req1_valid && (grant == 1'b1);
          accept     = req0_ready || req1_ready;
          if (accept) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (core_done) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      ptr    <= ~grant;
      rsp_id <= grant;
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  seq_mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .a       (op_a),
    .b       (op_b),
    .product (rsp_product),
    .done    (core_done)
  );

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - directed vector bench for the shared multiplier scheduler
module tb_mult_share_sched;

  localparam int W = 6;

  typedef struct {
    logic         v0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         v1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         id;
    logic [2*W-1:0] prod;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_product;
  logic [0:0]     rsp_id;
  logic           busy;

  int checks = 0;
  int errors = 0;
  vec_t vecs [10];

  always #5 clk = ~clk;

  mult_share_sched #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // entered at a negedge with the DUT idle; returns at the negedge after the response handshake
  task automatic run_vec(input int n, input vec_t v);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    rsp_ready  = 1'b0;
    #1;
    chk($sformatf("v%0d req0_ready", n), 32'(req0_ready), 32'(v.id == 1'b0));
    chk($sformatf("v%0d req1_ready", n), 32'(req1_ready), 32'(v.id == 1'b1));
    @(negedge clk);
    req0_a = ~v.a0; req0_b = ~v.b0;
    req1_a = ~v.a1; req1_b = ~v.b1;
    for (int k = 0; k < W; k++) begin
      chk($sformatf("v%0d wait%0d rsp_valid", n, k), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d wait%0d busy", n, k), 32'(busy), 32'd1);
      chk($sformatf("v%0d wait%0d ready", n, k), 32'(req0_ready | req1_ready), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d rsp_product", n), 32'(rsp_product), 32'(v.prod));
    chk($sformatf("v%0d rsp_id", n), 32'(rsp_id), 32'(v.id));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_valid after", n), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 6'd11, 6'd12, 1'b1, 6'd17, 6'd0,  1'b0, 12'd132};
    vecs[1] = '{1'b1, 6'd11, 6'd12, 1'b1, 6'd17, 6'd0,  1'b1, 12'd0};
    vecs[2] = '{1'b1, 6'd57, 6'd32, 1'b0, 6'd0,  6'd0,  1'b0, 12'd1824};
    vecs[3] = '{1'b1, 6'd63, 6'd62, 1'b0, 6'd0,  6'd0,  1'b0, 12'd3906};
    vecs[4] = '{1'b0, 6'd0,  6'd0,  1'b1, 6'd5,  6'd7,  1'b1, 12'd35};
    vecs[5] = '{1'b1, 6'd3,  6'd4,  1'b1, 6'd9,  6'd9,  1'b0, 12'd12};
    vecs[6] = '{1'b1, 6'd3,  6'd4,  1'b1, 6'd9,  6'd9,  1'b1, 12'd81};
    vecs[7] = '{1'b1, 6'd63, 6'd63, 1'b1, 6'd1,  6'd1,  1'b0, 12'd3969};
    vecs[8] = '{1'b1, 6'd63, 6'd63, 1'b1, 6'd1,  6'd1,  1'b1, 12'd1};
    vecs[9] = '{1'b0, 6'd0,  6'd0,  1'b1, 6'd63, 6'd1,  1'b1, 12'd63};

    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 6'd11; req0_b = 6'd12;
    req1_valid = 1'b1; req1_a = 6'd17; req1_b = 6'd0;
    rsp_ready  = 1'b0;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rsp_product", 32'(rsp_product), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset req0_ready", 32'(req0_ready), 32'd0);
    chk("reset req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // response stall: pointer is 0 here, so req0 wins and req1 follows
    req0_valid = 1'b1; req0_a = 6'd25; req0_b = 6'd40;
    req1_valid = 1'b1; req1_a = 6'd2;  req1_b = 6'd3;
    #1;
    chk("stall req0_ready", 32'(req0_ready), 32'd1);
    chk("stall req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    repeat (W) @(negedge clk);
    chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d rsp_product", i), 32'(rsp_product), 32'd1000);
      chk($sformatf("stall%0d rsp_id", i), 32'(rsp_id), 32'd0);
      chk($sformatf("stall%0d ready", i), 32'(req0_ready | req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release req1_ready", 32'(req1_ready), 32'd1);
    chk("release req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk);
    chk("release busy", 32'(busy), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (W) @(negedge clk);
    chk("release rsp_valid2", 32'(rsp_valid), 32'd1);
    chk("release rsp_product", 32'(rsp_product), 32'd6);
    chk("release rsp_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // reset in the middle of RUN after a req0 grant moved the pointer to 1
    req0_valid = 1'b1; req0_a = 6'd63; req0_b = 6'd62;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun busy", 32'(busy), 32'd1);
    req0_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst rsp_product", 32'(rsp_product), 32'd0);
    chk("midrst rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("postrst%0d busy", i), 32'(busy), 32'd0);
    end
    run_vec(10, '{1'b1, 6'd63, 6'd62, 1'b1, 6'd1, 6'd2, 1'b0, 12'd3906});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
